// File: rtl/pcie_tl_rx_hdr_queue_if.sv
// Bundle for the RX header queue: TLP header input, decoded header output,
// error and flow-control sideband. The queue itself uses the slave modport.
interface pcie_tl_rx_hdr_queue_if #(
  parameter int TLP_W = 128,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Valid/ready rule for both streams: a transfer happens on a rising clk edge
  // where valid and ready are both 1; valid and its payload stay put until then.
  logic             tlp_valid_i;
  logic [TLP_W-1:0] tlp_i;
  logic             tlp_ready_o;

  logic             hdr_valid_o;
  logic             hdr_ready_i;
  logic             hdr_is_write_o;
  logic             hdr_is_4dw_o;
  logic [9:0]       hdr_len_o;
  logic [15:0]      hdr_req_id_o;
  logic [7:0]       hdr_tag_o;
  logic [7:0]       hdr_be_o;
  logic [63:0]      hdr_addr_o;

  logic             err_unsup_o;
  logic             fc_upd_valid_o;
  logic [CNT_W-1:0] fc_upd_cnt_o;
  logic [CNT_W-1:0] occupancy_o;

  modport master (
    output tlp_valid_i, tlp_i, hdr_ready_i,
    input  tlp_ready_o, hdr_valid_o, hdr_is_write_o, hdr_is_4dw_o, hdr_len_o,
           hdr_req_id_o, hdr_tag_o, hdr_be_o, hdr_addr_o, err_unsup_o,
           fc_upd_valid_o, fc_upd_cnt_o, occupancy_o
  );

  modport slave (
    input  tlp_valid_i, tlp_i, hdr_ready_i,
    output tlp_ready_o, hdr_valid_o, hdr_is_write_o, hdr_is_4dw_o, hdr_len_o,
           hdr_req_id_o, hdr_tag_o, hdr_be_o, hdr_addr_o, err_unsup_o,
           fc_upd_valid_o, fc_upd_cnt_o, occupancy_o
  );
endinterface

// File: rtl/pcie_tl_rx_hdr_queue.sv
// Receive TLP header queue: decodes MRd/MWr headers into a small FIFO, drops
// anything else with an error pulse, and returns header credits in batches.
module pcie_tl_rx_hdr_queue #(
  parameter int TLP_W         = 128,
  parameter int DEPTH         = 4,
  parameter int ADDR64_EN     = 1,
  parameter int FC_UPD_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pcie_tl_rx_hdr_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic        is_write;
    logic        is_4dw;
    logic [9:0]  len;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [7:0]  be;
    logic [63:0] addr;
  } hdr_t;

  logic [31:0] dw0, dw1, dw2, dw3;
  logic [2:0]  fmt;
  logic [4:0]  typ;
  logic        supported;
  hdr_t        dec;

  hdr_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic [CNT_W-1:0] acc, acc_next;
  logic             push_hs, push, drop, pop, fire;
  logic             err_q, fc_valid_q;
  logic [CNT_W-1:0] fc_cnt_q;
  hdr_t             head;

  assign dw0 = bus.tlp_i[TLP_W-1  -: 32];
  assign dw1 = bus.tlp_i[TLP_W-33 -: 32];
  assign dw2 = bus.tlp_i[TLP_W-65 -: 32];
  assign dw3 = bus.tlp_i[TLP_W-97 -: 32];
  assign fmt = dw0[31:29];
  assign typ = dw0[28:24];

  logic unused_tlp_bits;
  assign unused_tlp_bits = ^{dw0[23:10], dw3[1:0]};

  always_comb begin
    supported = 1'b0;
    if (typ == 5'b00000) begin
      case (fmt)
        3'b000, 3'b010: supported = 1'b1;
        3'b001, 3'b011: supported = (ADDR64_EN != 0);
        default:        supported = 1'b0;
      endcase
    end
  end

  always_comb begin
    dec          = '0;
    dec.is_write = fmt[1];
    dec.is_4dw   = fmt[0];
    dec.len      = dw0[9:0];
    dec.req_id   = dw1[31:16];
    dec.tag      = dw1[15:8];
    dec.be       = dw1[7:0];
    dec.addr     = fmt[0] ? {dw2, dw3[31:2], 2'b00} : {32'b0, dw2[31:2], 2'b00};
  end

  // Ready comes from the registered count only, so a pop at full is seen next cycle.
  assign bus.tlp_ready_o = rst_n & (count < CNT_W'(DEPTH));
  assign push_hs         = bus.tlp_valid_i & bus.tlp_ready_o;
  assign push            = push_hs & supported;
  assign drop            = push_hs & ~supported;
  assign pop             = bus.hdr_valid_o & bus.hdr_ready_i;

  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign acc_next   = acc + CNT_W'(pop) + CNT_W'(drop);
  // Flush a partial batch once the queue drains so no credit is stranded.
  assign fire = (acc_next >= CNT_W'(FC_UPD_THRESH)) ||
                ((acc_next != '0) && (count_next == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      acc        <= '0;
      err_q      <= 1'b0;
      fc_valid_q <= 1'b0;
      fc_cnt_q   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      err_q      <= drop;
      fc_valid_q <= fire;
      if (fire) begin
        fc_cnt_q <= acc_next;
        acc      <= '0;
      end else begin
        acc <= acc_next;
      end
    end
  end

  assign head               = mem[rd_ptr];
  assign bus.hdr_valid_o    = (count != '0);
  assign bus.hdr_is_write_o = head.is_write;
  assign bus.hdr_is_4dw_o   = head.is_4dw;
  assign bus.hdr_len_o      = head.len;
  assign bus.hdr_req_id_o   = head.req_id;
  assign bus.hdr_tag_o      = head.tag;
  assign bus.hdr_be_o       = head.be;
  assign bus.hdr_addr_o     = head.addr;
  assign bus.err_unsup_o    = err_q;
  assign bus.fc_upd_valid_o = fc_valid_q;
  assign bus.fc_upd_cnt_o   = fc_cnt_q;
  assign bus.occupancy_o    = count;
endmodule
